dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the 2048 x 16 data memory (synchronous single-port RAM, write-over-read priority, 1-cycle registered read).
- Lets two masters share the RAM: port 0 is the CPU datapath, port 1 is the debug/loader path.
- Accepts one transaction at a time, registers the command onto the RAM strobes, and returns read data with a valid pulse to the owning port.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a 2048 x 16 synchronous
// single-port data RAM (1-cycle registered read).
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   m0_* (port 0, CPU)      req/we/addr/wdata in; ack, rvalid, rdata out
//   m1_* (port 1, debug)    same as port 0
//   mem_rd, mem_wr          RAM read / write strobes, only high during ISSUE
//   mem_addr, mem_wdata     latched RAM address / write data, held while idle
//   mem_rdata               RAM read data, valid in the cycle after the read strobe
//   busy                    high whenever the sequencer is not idle
//   grant_id                port owning the current or last transaction
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 has fixed priority over port 1.
module dmem_arbiter #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AB-1:0] m0_addr,
  input  logic [DB-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_rvalid,
  output logic [DB-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AB-1:0] m1_addr,
  input  logic [DB-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_rvalid,
  output logic [DB-1:0] m1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AB-1:0] mem_addr,
  output logic [DB-1:0] mem_wdata,
  input  logic [DB-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            we_q;
  logic [AB-1:0]   addr_q;
  logic [DB-1:0]   wdata_q;
  logic            grant_q;
  logic [DB-1:0]   rdata0_q, rdata1_q;
  logic            any_req;
  logic            win;
  logic            accept;

  assign any_req = m0_req | m1_req;
  assign accept  = (state_q == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
  // Last-granted port; resets to 1 so port 0 wins the first tie.
  logic last_q;

  always_comb begin
    if (m0_req && m1_req) win = ~last_q;
    else                  win = ~m0_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_q <= 1'b1;
    else if (accept) last_q <= win;
  end
`else
  always_comb begin
    win = ~m0_req;
  end
`endif

  // State register plus the transaction latch and per-port read data holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= win;
        we_q    <= win ? m1_we    : m0_we;
        addr_q  <= win ? m1_addr  : m0_addr;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
      if (state_q == RDATA) begin
        if (grant_q) rdata1_q <= mem_rdata;
        else         rdata0_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so a reset drops the
  // strobes, acks and valids without waiting for a clock edge. During RDATA
  // the owner's rdata bypasses the hold register so data arrives with rvalid.
  always_comb begin
    m0_ack    = (state_q == ISSUE) && !grant_q;
    m1_ack    = (state_q == ISSUE) &&  grant_q;
    mem_wr    = (state_q == ISSUE) &&  we_q;
    mem_rd    = (state_q == ISSUE) && !we_q;
    m0_rvalid = (state_q == RDATA) && !grant_q;
    m1_rvalid = (state_q == RDATA) &&  grant_q;
    m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
    m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;
    busy      = (state_q != IDLE);
    grant_id  = grant_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [10:0] m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic        m0_ack, m0_rvalid;
  logic [15:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [10:0] m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic        m1_ack, m1_rvalid;
  logic [15:0] m1_rdata;
  logic        mem_rd, mem_wr;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy, grant_id;

  dmem_arbiter #(.AB(11), .DB(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous, write-over-read, registered read.
  logic [15:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    else if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  // Reference model state and scoreboard queues.
  typedef struct {int port; int cyc; bit we; logic [10:0] addr; logic [15:0] wdata;} ack_t;
  typedef struct {int port; int cyc; logic [15:0] data;} rv_t;
  ack_t        ackq[$];
  rv_t         rvq[$];
  int          glog[$];   // observed grant order
  int          mglog[$];  // model grant order
  logic [15:0] ref_mem [0:2047];
  logic [15:0] exp_rd [0:1];
  int          cyc = 0;
  int          m_cnt = 0;  // edges until the model is free to accept again
  int          last_w = 1;
  int          comps = 0;
  int          fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic miss(input string n);
    comps++;
    fails++;
    $display("FAIL %s: event not seen (cycle %0d)", n, cyc);
  endtask

  // Model: an accepted write occupies the arbiter for 2 cycles, a read for 3.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      if (m_cnt == 0) begin
        if (m0_req || m1_req) begin
          int w;
          ack_t a;
`ifdef DMEM_ARB_RR_EN
          if (m0_req && m1_req) w = 1 - last_w;
          else                  w = m0_req ? 0 : 1;
`else
          w = m0_req ? 0 : 1;
`endif
          last_w = w;
          mglog.push_back(w);
          a.port = w; a.cyc = cyc;
          a.we    = (w == 0) ? m0_we    : m1_we;
          a.addr  = (w == 0) ? m0_addr  : m1_addr;
          a.wdata = (w == 0) ? m0_wdata : m1_wdata;
          ackq.push_back(a);
          if (a.we) begin
            ref_mem[a.addr] = a.wdata;
            m_cnt = 1;
          end else begin
            rv_t r;
            r.port = w; r.cyc = cyc + 1; r.data = ref_mem[a.addr];
            rvq.push_back(r);
            m_cnt = 2;
          end
        end
      end else begin
        m_cnt--;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    bit          prev_ok = 0;
    logic [10:0] prev_addr = '0;
    logic [15:0] prev_wd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ok = 0;
        continue;
      end
      while (ackq.size() > 0 && ackq[0].cyc < cyc) begin
        miss("ack_missing");
        void'(ackq.pop_front());
      end
      if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
        ack_t e;
        e = ackq.pop_front();
        chk("m0_ack", m0_ack, e.port == 0);
        chk("m1_ack", m1_ack, e.port == 1);
        chk("mem_wr", mem_wr, e.we);
        chk("mem_rd", mem_rd, !e.we);
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        chk("grant_id", grant_id, e.port[0]);
        chk("busy_issue", busy, 1);
      end else if (m0_ack | m1_ack | mem_rd | mem_wr) begin
        chk("spurious_issue", {m0_ack, m1_ack, mem_rd, mem_wr}, 0);
      end
      if (m0_ack | m1_ack) glog.push_back(m1_ack ? 1 : 0);
      chk("strobe_excl", mem_rd & mem_wr, 0);

      while (rvq.size() > 0 && rvq[0].cyc < cyc) begin
        miss("rvalid_missing");
        void'(rvq.pop_front());
      end
      if (rvq.size() > 0 && rvq[0].cyc == cyc) begin
        rv_t r;
        r = rvq.pop_front();
        chk("m0_rvalid", m0_rvalid, r.port == 0);
        chk("m1_rvalid", m1_rvalid, r.port == 1);
        chk("busy_rdata", busy, 1);
        exp_rd[r.port] = r.data;
      end else if (m0_rvalid | m1_rvalid) begin
        chk("spurious_rvalid", {m0_rvalid, m1_rvalid}, 0);
      end
      chk("m0_rdata", m0_rdata, exp_rd[0]);
      chk("m1_rdata", m1_rdata, exp_rd[1]);

      if (!busy) begin
        if (prev_ok) begin
          chk("idle_addr_hold", mem_addr, prev_addr);
          chk("idle_wdata_hold", mem_wdata, prev_wd);
        end
        prev_ok = 1; prev_addr = mem_addr; prev_wd = mem_wdata;
      end else begin
        prev_ok = 0;
      end
    end
  end

  task automatic drive(input int p, input bit rq, input bit we,
                       input logic [10:0] a, input logic [15:0] d);
    if (p == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  // Present one transaction, hold it until acked, then release after the ack cycle.
  task automatic do_txn(input int p, input bit we, input logic [10:0] a, input logic [15:0] d);
    bit got = 0;
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_ack : m1_ack;
    end
    if (!got) miss("ack_timeout");
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, a, d);
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      bit          we;
      logic [10:0] a;
      logic [15:0] d;
      int          gap;
      we  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 7)) : 11'($urandom);
      d   = 16'($urandom);
      do_txn(p, we, a, d);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pre;
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_rvalids", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_strobes", {mem_rd, mem_wr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_grant", grant_id, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 write then read back.
    do_txn(0, 1'b1, 11'h005, 16'hBEEF);
    do_txn(0, 1'b0, 11'h005, 16'h0000);
    @(negedge clk); @(negedge clk);
    chk("m0_read_beef", m0_rdata, 16'hBEEF);
    @(posedge clk); #1;

    // Simultaneous writes.
    glog.delete(); mglog.delete();
    fork
      do_txn(0, 1'b1, 11'h010, 16'h1111);
      do_txn(1, 1'b1, 11'h011, 16'h2222);
    join
    repeat (3) @(negedge clk);
    chk("sim_glog_n", glog.size(), 2);
    if (glog.size() == 2 && mglog.size() == 2) begin
      chk("sim_g0", glog[0], mglog[0]);
      chk("sim_g1", glog[1], mglog[1]);
`ifndef DMEM_ARB_RR_EN
      chk("sim_fixed_g0", glog[0], 0);
      chk("sim_fixed_g1", glog[1], 1);
`endif
    end
    chk("ram_010", ram[11'h010], 16'h1111);
    chk("ram_011", ram[11'h011], 16'h2222);
    @(posedge clk); #1;

    // Both ports issue back-to-back reads, three each.
    glog.delete();
    fork
      begin
        do_txn(0, 1'b0, 11'h010, 16'h0); do_txn(0, 1'b0, 11'h011, 16'h0);
        do_txn(0, 1'b0, 11'h005, 16'h0);
      end
      begin
        do_txn(1, 1'b0, 11'h011, 16'h0); do_txn(1, 1'b0, 11'h005, 16'h0);
        do_txn(1, 1'b0, 11'h010, 16'h0);
      end
    join
    repeat (3) @(negedge clk);
    chk("rr_glog_n", glog.size(), 6);
    if (glog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
        chk("rr_alternate", glog[i], i % 2);
`else
        chk("fixed_order", glog[i], (i < 3) ? 0 : 1);
`endif
      end
    end
    @(posedge clk); #1;

    // Address boundaries.
    do_txn(0, 1'b1, 11'h7FF, 16'hFFFF);
    do_txn(1, 1'b1, 11'h000, 16'h0001);
    do_txn(0, 1'b0, 11'h7FF, 16'h0);
    @(negedge clk); @(negedge clk);
    chk("bound_7ff", m0_rdata, 16'hFFFF);
    @(posedge clk); #1;
    do_txn(1, 1'b0, 11'h000, 16'h0);
    @(negedge clk); @(negedge clk);
    chk("bound_000", m1_rdata, 16'h0001);
    @(posedge clk); #1;

    // Random mix, 100 transactions per port.
    fork
      rand_port(0, 100);
      rand_port(1, 100);
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset during ISSUE of a port 1 read.
    pre = ref_mem[2047];
    begin
      bit got = 0;
      drive(1, 1'b1, 1'b0, 11'h7FF, 16'h0);
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        got = m1_ack;
      end
      if (!got) miss("rst_ack_timeout");
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_acks", {m0_ack, m1_ack}, 0);
    chk("rst_mid_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_mid_strobes", {mem_rd, mem_wr}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_mid_grant", grant_id, 0);
    ackq.delete(); rvq.delete();
    m_cnt = 0; last_w = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    drive(1, 1'b0, 1'b0, 11'h0, 16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_rvalid", m1_rvalid, 0);
    @(posedge clk); #1;
    do_txn(0, 1'b0, 11'h7FF, 16'h0);
    @(negedge clk); @(negedge clk);
    chk("post_rst_read", m0_rdata, pre);

    repeat (5) @(negedge clk);
    chk("ackq_drained", ackq.size(), 0);
    chk("rvq_drained", rvq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
